// File: rtl/edge_detection_pkg.sv
// Shared types and constants for the streaming Sobel edge detector.
// The pixel and window types are fixed at the package pixel width.
package edge_detection_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned GRAD_W = 12;

  localparam logic [GRAD_W-1:0] MAX_PIX = 12'd255;

  typedef logic [DATA_W-1:0] pix_t;

  // [row][col]: row 0 is the oldest line, col 0 the oldest column.
  typedef logic [2:0][2:0][DATA_W-1:0] window_t;

  // Zero-extends a pixel into the signed gradient domain.
  function automatic logic signed [GRAD_W-1:0] pix_to_grad(input pix_t p);
    return $signed({{(GRAD_W - DATA_W){1'b0}}, p});
  endfunction

endpackage

// File: rtl/edge_detection_sobel_kernel.sv
// Combinational 3x3 Sobel operator: |Gx| + |Gy| saturated to the pixel range.
// Window row 0 is the top row of the neighbourhood, column 0 the left column.
module sobel_kernel
  import edge_detection_pkg::*;
(
  input  window_t win_i,
  output pix_t    mag_o
);

  logic signed [GRAD_W-1:0] gx;
  logic signed [GRAD_W-1:0] gy;
  logic        [GRAD_W-1:0] abs_gx;
  logic        [GRAD_W-1:0] abs_gy;
  logic        [GRAD_W-1:0] mag;

  always_comb begin
    gx = pix_to_grad(win_i[0][2])
       + (pix_to_grad(win_i[1][2]) <<< 1)
       + pix_to_grad(win_i[2][2])
       - pix_to_grad(win_i[0][0])
       - (pix_to_grad(win_i[1][0]) <<< 1)
       - pix_to_grad(win_i[2][0]);

    gy = pix_to_grad(win_i[2][0])
       + (pix_to_grad(win_i[2][1]) <<< 1)
       + pix_to_grad(win_i[2][2])
       - pix_to_grad(win_i[0][0])
       - (pix_to_grad(win_i[0][1]) <<< 1)
       - pix_to_grad(win_i[0][2]);
  end

  // Each magnitude is at most 1020, so the sum cannot overflow GRAD_W bits.
  always_comb begin
    abs_gx = gx[GRAD_W-1] ? GRAD_W'(-gx) : GRAD_W'(gx);
    abs_gy = gy[GRAD_W-1] ? GRAD_W'(-gy) : GRAD_W'(gy);
    mag    = abs_gx + abs_gy;
  end

  assign mag_o = (mag > MAX_PIX) ? MAX_PIX[DATA_W-1:0] : mag[DATA_W-1:0];

endmodule

// File: rtl/edge_detection.sv
// Streaming 3x3 Sobel edge detector: raster-order pixels in, one saturated
// gradient per interior pixel out, two clocks after the completing accept.
module edge_detection #(
  parameter int unsigned IMG_WIDTH  = 10,
  parameter int unsigned IMG_HEIGHT = 10,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pixel_input,
  input  logic              pixel_valid,
  output logic [DATA_W-1:0] edge_output,
  output logic              edge_output_valid
);

  import edge_detection_pkg::*;

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // Line buffers: prev1 holds row r-1, prev2 holds row r-2 at each column.
  pix_t lb_prev1_q [IMG_WIDTH];
  pix_t lb_prev2_q [IMG_WIDTH];

  window_t win_q, win_d;
  logic    done_q, done_d;

  pix_t kern_mag;
  pix_t mag_q, mag_d;
  logic mag_valid_q, mag_valid_d;
  pix_t out_q, out_d;
  logic out_valid_q, out_valid_d;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    done_d = 1'b0;
    if (pixel_valid) begin
      if (col_q == ColW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(IMG_HEIGHT - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_prev2_q[col_q];
      win_d[1][2] = lb_prev1_q[col_q];
      win_d[2][2] = pixel_input;
      done_d      = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    end
  end

  always_comb begin
    mag_d       = done_q ? kern_mag : mag_q;
    mag_valid_d = done_q;
    out_d       = mag_valid_q ? mag_q : out_q;
    out_valid_d = mag_valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      done_q      <= 1'b0;
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      done_q      <= done_d;
      mag_q       <= mag_d;
      mag_valid_q <= mag_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Contents are only consumed after being rewritten in the current frame,
  // so the buffers carry no reset.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      lb_prev2_q[col_q] <= lb_prev1_q[col_q];
      lb_prev1_q[col_q] <= pixel_input;
    end
  end

  sobel_kernel u_sobel_kernel (
    .win_i (win_q),
    .mag_o (kern_mag)
  );

  assign edge_output       = out_q;
  assign edge_output_valid = out_valid_q;

endmodule

// File: tb/tb_edge_detection.sv
// Self-checking bench for edge_detection: frame-level reference model with
// directed step/impulse frames, randomized frames, gaps and mid-frame reset.
module tb_edge_detection;

  localparam int W = 10;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pixel_input = 8'h00;
  logic       pixel_valid = 1'b0;
  logic [7:0] edge_output;
  logic       edge_output_valid;

  edge_detection #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .DATA_W     (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .pixel_input       (pixel_input),
    .pixel_valid       (pixel_valid),
    .edge_output       (edge_output),
    .edge_output_valid (edge_output_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: the current frame as a plain image, raster position,
  // and a queue of (cycle, value) strobes the DUT owes us.
  int         img [H][W];
  logic [7:0] rand_img [H][W];
  int         mr = 0;
  int         mc = 0;
  int         exp_t [$];
  int         exp_v [$];
  logic [7:0] last_out = 8'h00;

  int obs_strobes = 0;
  int obs_nz = 0;
  int obs_ff = 0;

  function automatic int model_sobel(input int cr, input int cc);
    int gx, gy, m;
    gx = (img[cr-1][cc+1] + 2 * img[cr][cc+1] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2 * img[cr][cc-1] + img[cr+1][cc-1]);
    gy = (img[cr+1][cc-1] + 2 * img[cr+1][cc] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2 * img[cr-1][cc] + img[cr-1][cc+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  function automatic logic [7:0] pattern(input int kind, input int r, input int c);
    case (kind)
      0: return 8'h80;
      1: return (r >= 5) ? 8'hFF : 8'h00;
      2: return (c >= 5) ? 8'hFF : 8'h00;
      3: return (r == 5 && c == 5) ? 8'h10 : 8'h00;
      default: return rand_img[r][c];
    endcase
  endfunction

  task automatic model_accept(input logic [7:0] p);
    img[mr][mc] = int'(p);
    if (mr >= 2 && mc >= 2) begin
      exp_t.push_back(cyc + 2);
      exp_v.push_back(model_sobel(mr - 1, mc - 1));
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic check_outputs();
    logic       want_v;
    logic [7:0] want;
    want_v = (exp_t.size() > 0) && (exp_t[0] == cyc);
    want   = want_v ? 8'(exp_v[0]) : last_out;
    vectors++;
    assert (edge_output_valid === want_v)
    else begin
      miscompares++;
      $error("FAIL strobe cyc=%0d observed=%b expected=%b", cyc, edge_output_valid, want_v);
    end
    vectors++;
    assert (edge_output === want)
    else begin
      miscompares++;
      $error("FAIL edge_output cyc=%0d observed=%02h expected=%02h", cyc, edge_output, want);
    end
    if (want_v) begin
      void'(exp_t.pop_front());
      void'(exp_v.pop_front());
      last_out = want;
    end
    if (edge_output_valid === 1'b1) begin
      obs_strobes++;
      if (edge_output != 8'h00) obs_nz++;
      if (edge_output == 8'hFF) obs_ff++;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic tick(input logic v, input logic [7:0] p);
    pixel_valid = v;
    pixel_input = p;
    @(posedge clk);
    cyc++;
    if (v && reset) model_accept(p);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_frame(input int kind, input int gap_mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap_mode == 2) repeat ($urandom_range(0, 3)) tick(1'b0, 8'($urandom));
        tick(1'b1, pattern(kind, r, c));
        if (gap_mode == 1) tick(1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic end_frame(input string tag, input int want_strobes, input int want_nz,
                           input int want_ff);
    repeat (3) tick(1'b0, 8'h00);
    vectors++;
    assert (obs_strobes == want_strobes)
    else begin
      miscompares++;
      $error("FAIL %s strobe count observed=%0d expected=%0d", tag, obs_strobes, want_strobes);
    end
    if (want_nz >= 0) begin
      vectors++;
      assert (obs_nz == want_nz)
      else begin
        miscompares++;
        $error("FAIL %s nonzero count observed=%0d expected=%0d", tag, obs_nz, want_nz);
      end
      vectors++;
      assert (obs_ff == want_ff)
      else begin
        miscompares++;
        $error("FAIL %s saturated count observed=%0d expected=%0d", tag, obs_ff, want_ff);
      end
    end
    obs_strobes = 0;
    obs_nz      = 0;
    obs_ff      = 0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        rand_img[r][c] = 8'($urandom);
  endtask

  // Asynchronous reset mid-cycle, then a pixel offered while reset is held.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    mr = 0;
    mc = 0;
    exp_t.delete();
    exp_v.delete();
    last_out = 8'h00;
    vectors++;
    assert (edge_output_valid === 1'b0 && edge_output === 8'h00)
    else begin
      miscompares++;
      $error("FAIL async_reset observed=%b/%02h expected=0/00", edge_output_valid, edge_output);
    end
    @(negedge clk);
    tick(1'b1, 8'hAA);
    reset = 1'b1;
    obs_strobes = 0;
    obs_nz      = 0;
    obs_ff      = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b1;

    send_frame(0, 0);
    end_frame("flat", 64, 0, 0);

    send_frame(1, 1);
    end_frame("hstep_gapped", 64, 16, 16);

    send_frame(2, 0);
    end_frame("vstep", 64, 16, 16);

    send_frame(3, 2);
    end_frame("impulse", 64, 8, 0);

    fill_random();
    for (int i = 0; i < 37; i++) tick(1'b1, rand_img[i / W][i % W]);
    do_reset();
    send_frame(1, 0);
    end_frame("hstep_after_reset", 64, 16, 16);

    fill_random();
    send_frame(4, 0);
    send_frame(4, 0);
    end_frame("two_frames", 128, -1, -1);

    repeat (3) begin
      fill_random();
      send_frame(4, 2);
      end_frame("random_gapped", 64, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_detection.md
Name: edge_detection

Overview:
- Streaming 3x3 Sobel edge detector for 8-bit greyscale pixels.
- Accepts one pixel per valid-qualified clock in raster order (row-major, column index fastest).
- Buffers two previous rows and emits a saturated gradient magnitude for every interior pixel.
- Sits between the pixel source and downstream thresholding/display logic.

Parameters:
- IMG_WIDTH, 10, pixels per row (>=3).
- IMG_HEIGHT, 10, rows per frame (>=3).
- DATA_W, 8, pixel and output width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- pixel_input  input  DATA_W  pixel sample; sampled only when pixel_valid=1.
- pixel_valid  input  1  qualifies pixel_input for this cycle; gaps of any length allowed.
- edge_output  output  DATA_W  gradient magnitude of the window centre pixel.
- edge_output_valid  output  1  one-cycle strobe; edge_output is meaningful only while high.

Behaviour:
- Reset (reset=0, asynchronous):
  - edge_output=0, edge_output_valid=0.
  - Column/row counters = 0, window registers = 0.
  - Line-buffer contents need not be cleared.
- Accept: rising edge with pixel_valid=1. With pixel_valid=0, no state changes and edge_output_valid drops to 0 next cycle.
- Position counters:
  - col increments per accepted pixel, wrapping IMG_WIDTH-1 -> 0 with row increment.
  - row wraps IMG_HEIGHT-1 -> 0; the next pixel starts a new frame with no extra handshake.
- Line buffers: two IMG_WIDTH-deep rows holding rows r-1 and r-2. On accept at (r,c), shift entry c down one row and write the new pixel.
- Window: 3x3 shift register. Each accept shifts in the column {row r-2[c], row r-1[c], new pixel}.
- Window completion: an accept at (r,c) with r>=2 and c>=2 completes the window centred on (r-1,c-1).
- Latency: edge_output_valid=1 for exactly one cycle, on the second rising edge after the completing accept (2-clock latency). It is never asserted for border pixels.
- Arithmetic, with p[i][j], i,j in {-1,0,1}, relative to the centre (i=row, j=column):
  - Gx = (p[-1][1]+2p[0][1]+p[1][1]) - (p[-1][-1]+2p[0][-1]+p[1][-1]).
  - Gy = (p[1][-1]+2p[1][0]+p[1][1]) - (p[-1][-1]+2p[-1][0]+p[-1][1]).
  - Both are 12-bit signed.
  - mag = |Gx|+|Gy|, 12-bit unsigned, max 2040.
  - edge_output = min(mag, 255).
- edge_output holds its last value while edge_output_valid=0.
- Back-to-back valids: throughput is 1 pixel/clock with no stalls, and the output strobe may stay high on consecutive cycles.
- Reset mid-frame: the frame is abandoned. The next accepted pixel is (0,0) and no outputs are produced until the window is complete again (r>=2, c>=2).
- Simultaneous reset and valid: reset wins and the pixel is dropped.
- Output count: (IMG_HEIGHT-2)*(IMG_WIDTH-2) strobes per frame; 64 for the defaults.

Decomposition:
- Package edge_detection_pkg holds:
  - DATA_W default and gradient width constant GRAD_W=12.
  - Saturation constant MAX_PIX=255.
  - Typedef pix_t (logic [DATA_W-1:0]).
  - Typedef window_t (3x3 array of pix_t).
- One sub-module, sobel_kernel: purely combinational, window_t in, saturated 8-bit magnitude out.
- Counters, line buffers, window and output registers live in edge_detection.

Test Plan:
- Flat frame, all pixels 0x80, 10x10 -> exactly 64 strobes, all edge_output=0x00.
- Horizontal step, rows 0-4 = 0x00 and rows 5-9 = 0xFF, valid every other cycle -> 64 strobes. Centres in rows 4 and 5 (cols 1-8) give 0xFF (Gy=1020, saturated); the other 48 give 0x00.
- Vertical step, cols 0-4 = 0x00 and cols 5-9 = 0xFF -> 0xFF for centre cols 4 and 5, 0x00 elsewhere. Strobe 2 clocks after each completing accept.
- Single bright pixel 0x10 at (5,5) in a zero frame -> the centre itself gives 0; its 4-neighbours give 0x20 (|Gx| or |Gy|=2*16); diagonal neighbours give 0x20 (16+16); all others 0.
- Reset asserted mid-frame after 37 pixels, then a full horizontal-step frame -> no strobe before the 23rd post-reset accept (first complete window at (2,2)); results match scenario 2.
- Two consecutive frames with continuous valid (no gaps) -> 128 strobes. The second frame's results are identical to the first, with no cross-frame window corruption at the row/frame wrap.
